// File: rtl/mandelbrot_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_wb_arbiter_if
//  Brief    : Lane result / pixel write-port bundle for mandelbrot_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mandelbrot_wb_arbiter_if #(
    parameter int NUM_LANES = 8,
    parameter int ITER_W    = 24,
    parameter int COORD_W   = 10
);
    logic [NUM_LANES-1:0]         lane_done;
    logic [NUM_LANES*ITER_W-1:0]  lane_iter;
    logic [NUM_LANES*COORD_W-1:0] lane_x;
    logic [NUM_LANES*COORD_W-1:0] lane_y;
    logic [NUM_LANES-1:0]         lane_ack;
    logic                         Ready;
    logic                         wEN;
    logic [23:0]                  RGB_out;
    logic [COORD_W-1:0]           x_coord;
    logic [COORD_W-1:0]           y_coord;
    logic                         frame_done;

    // Writeback block side
    modport slave (
        input  lane_done, lane_iter, lane_x, lane_y, Ready,
        output lane_ack, wEN, RGB_out, x_coord, y_coord, frame_done
    );

    // Engine lanes + framebuffer writer side
    modport master (
        output lane_done, lane_iter, lane_x, lane_y, Ready,
        input  lane_ack, wEN, RGB_out, x_coord, y_coord, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/mandelbrot_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_wb_arbiter
//  Brief    : Per-lane result slots drained round-robin through an
//             iteration-to-RGB map into one valid/ready pixel port.
//             Optional frame pixel counter enabled by `define PIXEL_COUNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mandelbrot_wb_arbiter #(
    parameter int NUM_LANES    = 8,
    parameter int ITER_W       = 24,
    parameter int COORD_W      = 10,
    parameter int MAX_ITER     = 255,
    parameter int FRAME_PIXELS = 307200
) (
    input  wire logic              aclk,
    input  wire logic              aresetn,
    mandelbrot_wb_arbiter_if.slave bus
);

    localparam int                c_ptr_w    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [ITER_W-1:0] c_max_iter = ITER_W'(MAX_ITER);

    if (NUM_LANES < 1 || NUM_LANES > 16 || ITER_W < 8 || COORD_W < 1 || FRAME_PIXELS < 1) begin : g_param_check
        $error("mandelbrot_wb_arbiter: illegal parameter set");
    end

    logic [NUM_LANES-1:0] r_full;
    logic [NUM_LANES-1:0] r_ack;
    logic [ITER_W-1:0]    r_slot_iter [NUM_LANES];
    logic [COORD_W-1:0]   r_slot_x    [NUM_LANES];
    logic [COORD_W-1:0]   r_slot_y    [NUM_LANES];
    logic [c_ptr_w-1:0]   r_ptr;

    logic                 r_wen;
    logic [23:0]          r_rgb;
    logic [COORD_W-1:0]   r_out_x;
    logic [COORD_W-1:0]   r_out_y;

    logic [NUM_LANES-1:0] w_cap;
    logic [NUM_LANES-1:0] w_grant;
    logic [c_ptr_w-1:0]   w_sel;
    logic [c_ptr_w-1:0]   w_idx;
    logic                 w_any;
    logic                 w_load;
    logic                 w_xfer;
    logic [ITER_W-1:0]    w_sel_iter;
    logic [23:0]          w_rgb;

    // Capture looks only at registered occupancy, so a slot drained on an
    // edge cannot refill on that same edge.
    assign w_cap  = bus.lane_done & ~r_full;
    assign w_xfer = r_wen & bus.Ready;
    assign w_load = w_any & (~r_wen | bus.Ready);

    always_comb begin : arbiter
        int idx;
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            w_idx = c_ptr_w'(idx);
            if (!w_any && r_full[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_grant    = w_load ? (NUM_LANES'(1) << w_sel) : '0;
    assign w_sel_iter = r_slot_iter[w_sel];
    assign w_rgb      = (w_sel_iter >= c_max_iter) ? 24'h000000
                      : {w_sel_iter[7:0], w_sel_iter[5:0], 2'b00, ~w_sel_iter[7:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_full <= '0;
            r_ack  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_slot_iter[i] <= '0;
                r_slot_x[i]    <= '0;
                r_slot_y[i]    <= '0;
            end
        end else begin
            r_ack  <= w_cap;
            r_full <= (r_full & ~w_grant) | w_cap;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_cap[i]) begin
                    r_slot_iter[i] <= bus.lane_iter[i*ITER_W +: ITER_W];
                    r_slot_x[i]    <= bus.lane_x[i*COORD_W +: COORD_W];
                    r_slot_y[i]    <= bus.lane_y[i*COORD_W +: COORD_W];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wen   <= 1'b0;
            r_rgb   <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_wen   <= 1'b1;
            r_rgb   <= w_rgb;
            r_out_x <= r_slot_x[w_sel];
            r_out_y <= r_slot_y[w_sel];
            r_ptr   <= w_sel;
        end else if (w_xfer) begin
            r_wen   <= 1'b0;
        end
    end

    assign bus.lane_ack = r_ack;
    assign bus.wEN      = r_wen;
    assign bus.RGB_out  = r_rgb;
    assign bus.x_coord  = r_out_x;
    assign bus.y_coord  = r_out_y;

`ifdef PIXEL_COUNT_EN
    localparam int c_cnt_w = $clog2(FRAME_PIXELS + 1);

    logic [c_cnt_w-1:0] r_pix_cnt;
    logic               r_frame;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pix_cnt <= '0;
            r_frame   <= 1'b0;
        end else if (w_xfer) begin
            if (r_pix_cnt == c_cnt_w'(FRAME_PIXELS - 1)) begin
                r_pix_cnt <= '0;
                r_frame   <= 1'b1;
            end else begin
                r_pix_cnt <= r_pix_cnt + c_cnt_w'(1);
                r_frame   <= 1'b0;
            end
        end else begin
            r_frame <= 1'b0;
        end
    end

    assign bus.frame_done = r_frame;
`else
    assign bus.frame_done = 1'b0;
`endif

endmodule
`default_nettype wire
